pc_unit: RTL and testbench

Registered program-counter stage for the MIPS pipeline, successor to the combinational next-PC mux. Each advancing cycle it selects the next address from four sources (sequential, branch, jump, JALR register). It also handles:
- stall hold,
- redirects that arrive while stalled (kept in a one-entry pending register),
- debug single-step,
- a halt state.

It feeds the instruction-memory address and the PC+4 value for link/branch arithmetic in IF.

---
 rtl/pc_unit_pkg.sv | 15 +
 rtl/pc_unit_mux_pc.sv | 42 ++++
 rtl/pc_unit.sv | 123 ++++++++++++
 tb/tb_pc_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared MIPS definitions for the fetch stage: PC FSM state encoding and
// default address constants used by pc_unit and its next-PC selector.
package pc_unit_pkg;

  // Program-counter stage state. HALTED is absorbing until reset.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_e;

  localparam int          SIZE_ADDR_PC_DEF = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int          INSTR_BYTES_DEF  = 4;

endpackage : pc_unit_pkg

// File: rtl/pc_unit_mux_pc.sv
// Combinational next-PC selector. Resolves the live redirect by fixed
// priority (branch > JALR > jump), then chooses live target, pending
// target or the sequential address, in that order.
module mux_pc #(
  parameter int SIZE_ADDR_PC = 32
) (
  input  logic                    i_pc_source,
  input  logic                    i_is_JALR,
  input  logic                    i_is_jump,
  input  logic [SIZE_ADDR_PC-1:0] i_suma_branch,
  input  logic [SIZE_ADDR_PC-1:0] i_rs,
  input  logic [SIZE_ADDR_PC-1:0] i_suma_jump,
  input  logic                    i_pending_valid,
  input  logic [SIZE_ADDR_PC-1:0] i_pending_target,
  input  logic [SIZE_ADDR_PC-1:0] i_pc4,
  output logic                    o_live_valid,
  output logic [SIZE_ADDR_PC-1:0] o_live_target,
  output logic [SIZE_ADDR_PC-1:0] o_next_pc
);

  // Live redirect: highest-priority asserted source wins.
  always_comb begin
    o_live_valid  = i_pc_source | i_is_JALR | i_is_jump;
    o_live_target = i_suma_jump;
    if (i_pc_source) begin
      o_live_target = i_suma_branch;
    end else if (i_is_JALR) begin
      o_live_target = i_rs;
    end
  end

  // Next address for an advancing cycle: live beats pending beats PC+4.
  always_comb begin
    o_next_pc = i_pc4;
    if (o_live_valid) begin
      o_next_pc = o_live_target;
    end else if (i_pending_valid) begin
      o_next_pc = i_pending_target;
    end
  end

endmodule : mux_pc

// File: rtl/pc_unit.sv
// Registered program counter for the MIPS fetch stage. Holds on stall,
// parks redirects that arrive while not advancing in a one-entry pending
// register (latest wins), supports debug single-step and a halt state.
// The FSM state is visible on o_halted (1 = HALTED, 0 = RUN).
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                      SIZE_ADDR_PC = SIZE_ADDR_PC_DEF,
  parameter logic [SIZE_ADDR_PC-1:0] RESET_VECTOR = SIZE_ADDR_PC'(RESET_VECTOR_DEF),
  parameter int                      INSTR_BYTES  = INSTR_BYTES_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_stall,
  input  logic                    i_step_mode,
  input  logic                    i_step,
  input  logic                    i_halt,
  input  logic                    i_pc_source,
  input  logic                    i_is_JALR,
  input  logic                    i_is_jump,
  input  logic [SIZE_ADDR_PC-1:0] i_suma_branch,
  input  logic [SIZE_ADDR_PC-1:0] i_rs,
  input  logic [SIZE_ADDR_PC-1:0] i_suma_jump,
  output logic [SIZE_ADDR_PC-1:0] o_pc,
  output logic [SIZE_ADDR_PC-1:0] o_pc4,
  output logic                    o_halted,
  output logic                    o_redirect_pending
);

  pc_state_e               r_state;
  pc_state_e               w_state_next;
  logic                    w_run;
  logic                    w_adv;
  logic                    w_capture;
  logic [SIZE_ADDR_PC-1:0] r_pc;
  logic                    r_pend_valid;
  logic [SIZE_ADDR_PC-1:0] r_pend_target;
  logic [SIZE_ADDR_PC-1:0] w_pc4;
  logic                    w_live_valid;
  logic [SIZE_ADDR_PC-1:0] w_live_target;
  logic [SIZE_ADDR_PC-1:0] w_next_pc;

  // State register: reset always returns to RUN, even from HALTED.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: halt is taken from RUN regardless of stall/step/redirects.
  always_comb begin
    w_state_next = r_state;
    if ((r_state == ST_RUN) && i_halt) begin
      w_state_next = ST_HALTED;
    end
  end

  // State-decoded outputs.
  always_comb begin
    w_run    = (r_state == ST_RUN);
    o_halted = (r_state == ST_HALTED);
  end

  // Advance and capture qualifiers; halt blocks both in its own cycle.
  always_comb begin
    w_adv     = w_run && !i_stall && !i_halt && (!i_step_mode || i_step);
    w_capture = w_run && !i_halt && !w_adv && w_live_valid;
  end

  // Sequential address, wraps modulo 2^SIZE_ADDR_PC.
  always_comb begin
    w_pc4 = r_pc + SIZE_ADDR_PC'(INSTR_BYTES);
  end

  mux_pc #(
    .SIZE_ADDR_PC (SIZE_ADDR_PC)
  ) u_mux_pc (
    .i_pc_source      (i_pc_source),
    .i_is_JALR        (i_is_JALR),
    .i_is_jump        (i_is_jump),
    .i_suma_branch    (i_suma_branch),
    .i_rs             (i_rs),
    .i_suma_jump      (i_suma_jump),
    .i_pending_valid  (r_pend_valid),
    .i_pending_target (r_pend_target),
    .i_pc4            (w_pc4),
    .o_live_valid     (w_live_valid),
    .o_live_target    (w_live_target),
    .o_next_pc        (w_next_pc)
  );

  // PC register: loads the selected next address only on advancing cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= RESET_VECTOR;
    end else if (w_adv) begin
      r_pc <= w_next_pc;
    end
  end

  // Pending redirect: consumed on every advance, overwritten by later redirects.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (w_adv) begin
      r_pend_valid  <= 1'b0;
    end else if (w_capture) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= w_live_target;
    end
  end

  // Output drive.
  always_comb begin
    o_pc               = r_pc;
    o_pc4              = w_pc4;
    o_redirect_pending = r_pend_valid;
  end

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a vector table for the single-cycle
// behaviour plus hand-written halt/wrap and reset-with-pending sequences.
// Two instances share stimulus; u_dut0 uses vector 0, u_dut1 0xFFFF_FFF8.
module tb_pc_unit;

  localparam int          W   = 32;
  localparam logic [W-1:0] RV1 = 32'hFFFF_FFF8;

  logic         clk;
  logic         reset;
  logic         stall, step_mode, step, halt;
  logic         pc_source, is_jalr, is_jump;
  logic [W-1:0] suma_branch, rs, suma_jump;
  logic [W-1:0] pc0, pc4_0, pc1, pc4_1;
  logic         halted0, pend0, halted1, pend1;

  int n_checks;
  int n_errors;

  typedef struct {
    logic         stall;
    logic         step_mode;
    logic         step;
    logic         pc_source;
    logic         is_jalr;
    logic         is_jump;
    logic [W-1:0] branch;
    logic [W-1:0] rs;
    logic [W-1:0] jump;
    logic [W-1:0] exp_pc;
    logic         exp_pend;
  } vec_t;

  vec_t vecs[$];

  pc_unit #(.SIZE_ADDR_PC(W), .RESET_VECTOR(32'h0), .INSTR_BYTES(4)) u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_step_mode(step_mode),
    .i_step(step), .i_halt(halt), .i_pc_source(pc_source), .i_is_JALR(is_jalr),
    .i_is_jump(is_jump), .i_suma_branch(suma_branch), .i_rs(rs),
    .i_suma_jump(suma_jump), .o_pc(pc0), .o_pc4(pc4_0), .o_halted(halted0),
    .o_redirect_pending(pend0)
  );

  pc_unit #(.SIZE_ADDR_PC(W), .RESET_VECTOR(RV1), .INSTR_BYTES(4)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_step_mode(step_mode),
    .i_step(step), .i_halt(halt), .i_pc_source(pc_source), .i_is_JALR(is_jalr),
    .i_is_jump(is_jump), .i_suma_branch(suma_branch), .i_rs(rs),
    .i_suma_jump(suma_jump), .o_pc(pc1), .o_pc4(pc4_1), .o_halted(halted1),
    .o_redirect_pending(pend1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; step_mode = 0; step = 0; halt = 0;
    pc_source = 0; is_jalr = 0; is_jump = 0;
    suma_branch = '0; rs = '0; suma_jump = '0;
  endtask

  task automatic add(input logic st, input logic sm, input logic sp,
                     input logic br, input logic jr, input logic jp,
                     input logic [W-1:0] b, input logic [W-1:0] r, input logic [W-1:0] j,
                     input logic [W-1:0] epc, input logic epend);
    vec_t v;
    v.stall = st; v.step_mode = sm; v.step = sp;
    v.pc_source = br; v.is_jalr = jr; v.is_jump = jp;
    v.branch = b; v.rs = r; v.jump = j;
    v.exp_pc = epc; v.exp_pend = epend;
    vecs.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();

    //   st sm sp br jr jp branch      rs          jump        exp_pc      pend
    add(0, 0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h4,     0); // sequential
    add(0, 0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h8,     0);
    add(0, 0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'hC,     0);
    add(0, 0, 0, 1, 1, 1, 32'h40,    32'h100,   32'h80,    32'h40,    0); // branch wins
    add(0, 0, 0, 0, 1, 1, 32'h40,    32'h100,   32'h80,    32'h100,   0); // JALR beats jump
    add(1, 0, 0, 0, 0, 1, 32'h0,     32'h0,     32'h200,   32'h100,   1); // captured under stall
    add(1, 0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h100,   1);
    add(1, 0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h100,   1);
    add(0, 0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h200,   0); // pending taken
    add(0, 0, 0, 1, 0, 0, 32'h20,    32'h0,     32'h0,     32'h20,    0);
    add(0, 1, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h20,    0); // step mode, no step
    add(0, 1, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h20,    0);
    add(0, 1, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h20,    0);
    add(0, 1, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h20,    0);
    add(0, 1, 1, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h24,    0); // single step
    add(0, 1, 1, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h28,    0); // two-cycle step
    add(0, 1, 1, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h2C,    0);
    add(0, 0, 1, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h30,    0); // step ignored
    add(0, 1, 0, 0, 0, 1, 32'h0,     32'h0,     32'h500,   32'h30,    1); // capture in step mode
    add(0, 1, 1, 0, 1, 0, 32'h0,     32'h600,   32'h0,     32'h600,   0); // live beats pending
    add(1, 0, 0, 0, 0, 1, 32'h0,     32'h0,     32'h700,   32'h600,   1);
    add(1, 0, 0, 1, 0, 0, 32'h740,   32'h0,     32'h0,     32'h600,   1); // latest wins
    add(0, 0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h740,   0);
    add(0, 0, 0, 0, 0, 0, 32'h0,     32'h0,     32'h0,     32'h744,   0);

    // Reset state
    reset = 1;
    tick();
    check("reset_pc", pc0, 32'h0);
    check("reset_pc4", pc4_0, 32'h4);
    check("reset_halted", {31'b0, halted0}, 32'h0);
    check("reset_pend", {31'b0, pend0}, 32'h0);
    check("reset_pc_rv1", pc1, RV1);
    reset = 0;

    // Table-driven run on u_dut0
    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; step_mode = vecs[i].step_mode; step = vecs[i].step;
      pc_source = vecs[i].pc_source; is_jalr = vecs[i].is_jalr; is_jump = vecs[i].is_jump;
      suma_branch = vecs[i].branch; rs = vecs[i].rs; suma_jump = vecs[i].jump;
      tick();
      check($sformatf("vec%0d_pc", i), pc0, vecs[i].exp_pc);
      check($sformatf("vec%0d_pc4", i), pc4_0, vecs[i].exp_pc + 32'd4);
      check($sformatf("vec%0d_pend", i), {31'b0, pend0}, {31'b0, vecs[i].exp_pend});
      check($sformatf("vec%0d_halted", i), {31'b0, halted0}, 32'h0);
    end

    // Halt and wrap on u_dut1
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    check("wrap_start", pc1, RV1);
    tick();
    check("wrap_pc_fffc", pc1, 32'hFFFF_FFFC);
    check("wrap_pc4_zero", pc4_1, 32'h0);
    tick();
    check("wrap_pc_zero", pc1, 32'h0);
    halt = 1; pc_source = 1; suma_branch = 32'h40;
    tick();
    check("halt_halted", {31'b0, halted1}, 32'h1);
    check("halt_pc_hold", pc1, 32'h0);
    halt = 0;
    for (int i = 0; i < 5; i++) begin
      pc_source = (i % 2 == 0); is_jump = 1; suma_jump = 32'h900;
      stall = (i == 3);
      tick();
      check($sformatf("halted_pc_c%0d", i), pc1, 32'h0);
      check($sformatf("halted_pend_c%0d", i), {31'b0, pend1}, 32'h0);
      check($sformatf("halted_flag_c%0d", i), {31'b0, halted1}, 32'h1);
    end
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    check("unhalt_pc", pc1, RV1);
    check("unhalt_halted", {31'b0, halted1}, 32'h0);

    // Reset while a redirect is pending
    stall = 1; is_jump = 1; suma_jump = 32'h300;
    tick();
    check("mid_pend_set", {31'b0, pend0}, 32'h1);
    check("mid_pend_pc", pc0, 32'h0);
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    check("mid_rst_pend", {31'b0, pend0}, 32'h0);
    check("mid_rst_pc", pc0, 32'h0);
    check("mid_rst_pend_rv1", {31'b0, pend1}, 32'h0);
    check("mid_rst_pc_rv1", pc1, RV1);
    tick();
    check("mid_after_pc", pc0, 32'h4);
    check("mid_after_pc_rv1", pc1, 32'hFFFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc_unit
